uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 18 +
 rtl/baud_tick_gen.sv | 28 ++
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the transmitter state set.
package uart_pkg;

  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam logic UART_IDLE_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..MOD_VALUE-1 while enabled, held at 0 otherwise.
module baud_tick_gen #(
  parameter int MOD_VALUE = 868,
  parameter int BIT_WIDTH = $clog2(MOD_VALUE)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam logic [BIT_WIDTH-1:0] LAST_COUNT = BIT_WIDTH'(MOD_VALUE - 1);

  logic [BIT_WIDTH-1:0] count;

  assign tick = enable && (count == LAST_COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + BIT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit after the payload.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  baud_tick_gen #(
    .MOD_VALUE (CLKS_PER_BIT),
    .BIT_WIDTH ($clog2(CLKS_PER_BIT))
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy),
    .tick    (bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tx_out     <= UART_IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle is the tail of the previous frame, so a request there is dropped.
        ST_IDLE: begin
          if (send && !done) begin
            shift_reg  <= din;
            bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^din;
`endif
            state      <= ST_START;
            busy       <= 1'b1;
            tx_out     <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state  <= ST_DATA;
            tx_out <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state  <= ST_PARITY;
              tx_out <= parity_bit;
`else
              state  <= ST_STOP;
              tx_out <= UART_IDLE_LEVEL;
`endif
            end else begin
              tx_out <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            state  <= ST_STOP;
            tx_out <= UART_IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_out <= UART_IDLE_LEVEL;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-slot reference model plus literal frame checks.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P         = 1;
  localparam int LIT_FRAME = 44;
  localparam int LIT_FRAME2 = 16;
  localparam logic [DB+P+1:0] LIT_A5 = 11'b10101001010;
  localparam logic [DB+P+1:0] LIT_07 = 11'b11000001110;
  localparam logic [DB+P+1:0] LIT_03 = 11'b10000000110;
  localparam logic [7:0]      LIT_1F = 8'b11111110;
`else
  localparam int P         = 0;
  localparam int LIT_FRAME = 40;
  localparam int LIT_FRAME2 = 14;
  localparam logic [DB+P+1:0] LIT_A5 = 10'b1101001010;
  localparam logic [DB+P+1:0] LIT_07 = 10'b1000001110;
  localparam logic [DB+P+1:0] LIT_03 = 10'b1000000110;
  localparam logic [6:0]      LIT_1F = 7'b1111110;
`endif
  localparam int NBITS = DB + P + 2;
  localparam int FRAME = NBITS * CPB;
  localparam int CPB2  = 2;
  localparam int DB2   = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          send = 1'b0;
  logic [DB-1:0] din = '0;
  logic          tx_out, busy, done;
  logic          send2 = 1'b0;
  logic [DB2-1:0] din2 = '0;
  logic          tx2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .send(send), .din(din),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .DATA_BITS(DB2)) dut2 (
    .clk(clk), .reset_n(reset_n), .send(send2), .din(din2),
    .tx_out(tx2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for every bit slot of a frame, slot 0 first.
  function automatic logic [NBITS-1:0] frame_bits(input logic [DB-1:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Reference: a frame is FRAME cycles indexed by m_t since acceptance, then one done cycle.
  logic             m_active = 1'b0;
  logic             m_done = 1'b0;
  int               m_t = 0;
  logic [NBITS-1:0] m_frame = '1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (send && !m_done) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_frame  <= frame_bits(din);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("model_tx", tx_out, m_active ? m_frame[m_t / CPB] : 1'b1);
    check("model_busy", busy, m_active);
    check("model_done", done, m_done);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called at the first cycle after acceptance; ends on the done cycle.
  task automatic check_frame(input string name, input logic [NBITS-1:0] exp);
    for (int t = 0; t <= LIT_FRAME; t++) begin
      if (t < LIT_FRAME) begin
        check({name, "_tx"}, tx_out, exp[t / CPB]);
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_nodone"}, done, 1'b0);
        step();
      end else begin
        check({name, "_done"}, done, 1'b1);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_tx"}, tx_out, 1'b1);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    step(3);
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx2", tx2, 1'b1);
    check("rst_busy2", busy2, 1'b0);

    reset_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      check("idle_tx", tx_out, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // Send presented as reset releases: accepted on the first edge.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    send = 1'b1;
    din = 8'hA5;
    step();
    send = 1'b0;
    check("first_accept_busy", busy, 1'b1);
    check_frame("a5", LIT_A5);
    step(2);

    send = 1'b1;
    din = 8'h07;
    step();
    send = 1'b0;
    check_frame("x07", LIT_07);
    step(3);
    send = 1'b1;
    din = 8'h03;
    step();
    send = 1'b0;
    check_frame("x03", LIT_03);
    step(2);

    // Send held high through a whole frame, din cleared mid-frame.
    send = 1'b1;
    din = 8'hA5;
    step();
    for (int t = 0; t <= LIT_FRAME + 2; t++) begin
      if (t == 13) din = 8'h00;
      if (t < LIT_FRAME) check("hold_tx", tx_out, LIT_A5[t / CPB]);
      if (t == LIT_FRAME) check("hold_done", done, 1'b1);
      if (t == LIT_FRAME + 1) begin
        check("hold_gap_busy", busy, 1'b0);
        check("hold_gap_done", done, 1'b0);
      end
      if (t == LIT_FRAME + 2) begin
        check("hold_restart_busy", busy, 1'b1);
        check("hold_restart_tx", tx_out, 1'b0);
      end
      if (t < LIT_FRAME + 2) step();
    end
    send = 1'b0;
    step(LIT_FRAME + 2);

    // Reset 13 cycles into a frame.
    send = 1'b1;
    din = 8'hA5;
    step();
    send = 1'b0;
    step(13);
    reset_n = 1'b0;
    #1;
    check("abort_tx", tx_out, 1'b1);
    check("abort_busy", busy, 1'b0);
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      check("abort_nodone", done, 1'b0);
    end
    send = 1'b1;
    din = 8'hA5;
    step();
    send = 1'b0;
    check_frame("after_abort", LIT_A5);
    step(2);

    // Smallest legal configuration.
    send2 = 1'b1;
    din2 = 5'h1F;
    step();
    send2 = 1'b0;
    for (int t = 0; t <= LIT_FRAME2; t++) begin
      if (t < LIT_FRAME2) begin
        check("small_tx", tx2, LIT_1F[t / CPB2]);
        check("small_busy", busy2, 1'b1);
        step();
      end else begin
        check("small_done", done2, 1'b1);
        check("small_idle_busy", busy2, 1'b0);
      end
    end
    step(2);

    for (int i = 0; i < 3000; i++) begin
      send = ($urandom_range(0, 3) == 0);
      din = DB'($urandom);
      reset_n = ($urandom_range(0, 599) != 0);
      step();
    end
    send = 1'b0;
    reset_n = 1'b1;
    step(FRAME + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
